// File: rtl/ins_pkg.sv
// Shared field map, length encoding and assembler states for the instruction fetch/decode path.
// Field positions refer to bits [15:0] of the head word.
package ins_pkg;

  localparam int MODE_HI   = 15;
  localparam int MODE_LO   = 14;
  localparam int LEN_HI    = 13;
  localparam int LEN_LO    = 12;
  localparam int OPCODE_HI = 11;
  localparam int OPCODE_LO = 8;
  localparam int OP1_HI    = 7;
  localparam int OP1_LO    = 5;
  localparam int OP2_HI    = 4;
  localparam int OP2_LO    = 2;
  localparam int OT_HI     = 1;
  localparam int OT_LO     = 0;

  localparam logic [1:0] LEN_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    S_HEAD = 2'd0,
    S_EXT  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // An illegal length carries no extension words.
  function automatic logic [1:0] ext_words(input logic [1:0] len);
    return (len == LEN_ILLEGAL) ? 2'd0 : len;
  endfunction

endpackage

// File: rtl/ins_fifo.sv
// Prefetch FIFO: DEPTH-entry register array, read data taken straight from the head slot.
// Push is refused when full (even with a same-cycle pop); flush empties it on the next edge.
module ins_fifo #(
  parameter int IW    = 16,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [IW-1:0] push_dat,
  input  logic          pop,
  output logic [IW-1:0] pop_dat,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [IW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign pop_dat = mem[rd_ptr];

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/ins_fetch_decoder.sv
// Prefetches ROM words, assembles head + extension words and presents decoded fields via valid/ready.
// Head popped one cycle after it lands in the FIFO; outputs hold until out_ready, next head follows with no bubble.
module ins_fetch_decoder
  import ins_pkg::*;
#(
  parameter int IW      = 16,
  parameter int DEPTH   = 4,
  parameter int MAX_EXT = 2,
  localparam int CW     = $clog2(DEPTH + 1),
  localparam int EW     = (MAX_EXT > 1) ? $clog2(MAX_EXT) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [IW-1:0] in_word,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    out_mode,
  output logic [1:0]    out_len,
  output logic [3:0]    out_opcode,
  output logic [2:0]    out_op1,
  output logic [2:0]    out_op2,
  output logic [1:0]    out_ot,
  output logic [IW-1:0] out_word0,
  output logic [IW-1:0] out_ext0,
  output logic [IW-1:0] out_ext1,
  output logic          out_illegal,
  output logic [CW-1:0] fifo_count
);

  state_t        state;
  state_t        state_nxt;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [IW-1:0] fifo_dat;
  logic          load_head;
  logic          load_ext;
  logic [IW-1:0] head_q;
  logic [IW-1:0] ext_q [MAX_EXT];
  logic [EW-1:0] ext_cnt_q;
  logic [1:0]    need_q;
  logic [1:0]    ext_last;

  assign in_ready = !fifo_full && !flush;
  assign fifo_pop = load_head || load_ext;
  assign ext_last = need_q - 2'd1;

  ins_fifo #(
    .IW    (IW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .push     (in_valid && in_ready),
    .push_dat (in_word),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_HEAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_head = 1'b0;
    load_ext  = 1'b0;
    if (flush) begin
      state_nxt = S_HEAD;
    end else begin
      case (state)
        S_HEAD: begin
          if (!fifo_empty) load_head = 1'b1;
        end
        S_EXT: begin
          if (!fifo_empty) begin
            load_ext = 1'b1;
            if (2'(ext_cnt_q) == ext_last) state_nxt = S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            if (!fifo_empty) load_head = 1'b1;
            else             state_nxt = S_HEAD;
          end
        end
        default: state_nxt = S_HEAD;
      endcase
      // A freshly popped head decides the branch, whichever state popped it.
      if (load_head) begin
        state_nxt = (ext_words(fifo_dat[LEN_HI:LEN_LO]) == 2'd0) ? S_HOLD : S_EXT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q    <= '0;
      need_q    <= '0;
      ext_cnt_q <= '0;
      for (int i = 0; i < MAX_EXT; i++) ext_q[i] <= '0;
    end else if (load_head) begin
      head_q    <= fifo_dat;
      need_q    <= ext_words(fifo_dat[LEN_HI:LEN_LO]);
      ext_cnt_q <= '0;
      for (int i = 0; i < MAX_EXT; i++) ext_q[i] <= '0;
    end else if (load_ext) begin
      ext_q[ext_cnt_q] <= fifo_dat;
      ext_cnt_q        <= ext_cnt_q + 1'b1;
    end
  end

  assign out_valid   = (state == S_HOLD);
  assign out_mode    = head_q[MODE_HI:MODE_LO];
  assign out_len     = head_q[LEN_HI:LEN_LO];
  assign out_opcode  = head_q[OPCODE_HI:OPCODE_LO];
  assign out_op1     = head_q[OP1_HI:OP1_LO];
  assign out_op2     = head_q[OP2_HI:OP2_LO];
  assign out_ot      = head_q[OT_HI:OT_LO];
  assign out_word0   = head_q;
  assign out_ext0    = ext_q[0];
  assign out_ext1    = ext_q[1];
  assign out_illegal = (head_q[LEN_HI:LEN_LO] == LEN_ILLEGAL);

endmodule
